ram16x8_arbiter: RTL and testbench

Two-client access controller for the 16x8 synchronous dual-port RAM. Clients A and B each issue single-beat read or write requests. The block steers granted writes to the RAM write port and granted reads to the RAM read port, so one write and one read can proceed in the same cycle. It resolves contention per port with round-robin, blocks same-address read-during-write, returns read data with a valid strobe, and clears the RAM to a fixed value after reset or on demand.

---
 rtl/ram16x8_arbiter_pkg.sv | 19 +
 rtl/ram16x8_arbiter_if.sv | 37 +++
 rtl/ram16x8_arbiter_rr_arb2.sv | 32 +++
 rtl/ram16x8_arbiter.sv | 123 ++++++++++++
 tb/tb_ram16x8_arbiter.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/ram16x8_arbiter_pkg.sv
// Shared types and constants for the 16x8 dual-port RAM access controller.
package ram16x8_arbiter_pkg;

  localparam int unsigned RAM_WIDTH = 8;
  localparam int unsigned RAM_DEPTH = 16;
  localparam int unsigned ADDR_SIZE = 4;

  localparam logic [RAM_WIDTH-1:0] INIT_VALUE = 8'h00;

  // Client ids double as bit positions in the request/grant vectors.
  localparam int unsigned CLI_A = 0;
  localparam int unsigned CLI_B = 1;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/ram16x8_arbiter_if.sv
// Client-side request/grant/read-return bus for both RAM clients.
interface ram16x8_arbiter_if;
  import ram16x8_arbiter_pkg::*;

  logic                 a_req;
  logic                 a_we;
  logic [ADDR_SIZE-1:0] a_addr;
  logic [RAM_WIDTH-1:0] a_wdata;
  logic                 a_gnt;
  logic                 a_rvalid;
  logic [RAM_WIDTH-1:0] a_rdata;

  logic                 b_req;
  logic                 b_we;
  logic [ADDR_SIZE-1:0] b_addr;
  logic [RAM_WIDTH-1:0] b_wdata;
  logic                 b_gnt;
  logic                 b_rvalid;
  logic [RAM_WIDTH-1:0] b_rdata;

  // Clients issue requests and receive grants and read data.
  modport master (
    output a_req, a_we, a_addr, a_wdata,
    output b_req, b_we, b_addr, b_wdata,
    input  a_gnt, a_rvalid, a_rdata,
    input  b_gnt, b_rvalid, b_rdata
  );

  // The arbiter accepts requests and returns grants and read data.
  modport slave (
    input  a_req, a_we, a_addr, a_wdata,
    input  b_req, b_we, b_addr, b_wdata,
    output a_gnt, a_rvalid, a_rdata,
    output b_gnt, b_rvalid, b_rdata
  );

endinterface

// File: rtl/ram16x8_arbiter_rr_arb2.sv
// Two-input round-robin arbiter; pointer names the client favoured on a tie.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       upd,
  output logic [1:0] gnt,
  output logic       ptr
);

  logic ptr_q;

  // Tie goes to the pointer's client; a lone requester always wins.
  always_comb begin
    gnt = req;
    if (req == 2'b11) begin
      gnt = ptr_q ? 2'b10 : 2'b01;
    end
  end

  // After an accepted grant, favour the other client next time.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= 1'b0;
    end else if (upd && (gnt != 2'b00)) begin
      ptr_q <= ~gnt[1];
    end
  end

  assign ptr = ptr_q;

endmodule

// File: rtl/ram16x8_arbiter.sv
// Two-client controller for a 16x8 dual-port RAM: per-port round-robin,
// same-address read-during-write blocking, read return and RAM clear.
module ram16x8_arbiter
  import ram16x8_arbiter_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  ram16x8_arbiter_if.slave     bus,
  input  logic                 init_req,
  output logic                 init_busy,
  output logic                 ram_wr_en,
  output logic                 ram_rd_en,
  output logic [ADDR_SIZE-1:0] ram_wr_addr,
  output logic [ADDR_SIZE-1:0] ram_rd_addr,
  output logic [RAM_WIDTH-1:0] ram_d_in,
  input  logic [RAM_WIDTH-1:0] ram_d_out
);

  state_e               state_q, state_d;
  logic [ADDR_SIZE-1:0] clr_cnt_q, clr_cnt_d;
  logic [1:0]           rvalid_q;

  logic                 run;
  logic [1:0]           wr_req, rd_req;
  logic [1:0]           wr_gnt, rd_win, rd_gnt;
  logic                 wptr, rptr;
  logic                 wr_idx, rd_idx;
  logic [ADDR_SIZE-1:0] wr_addr, rd_addr;
  logic [RAM_WIDTH-1:0] wr_data;
  logic                 hazard;

  assign run = (state_q == ST_RUN);

  // Split requests into per-port candidates; nothing competes during a clear.
  assign wr_req[CLI_A] = run & bus.a_req &  bus.a_we;
  assign wr_req[CLI_B] = run & bus.b_req &  bus.b_we;
  assign rd_req[CLI_A] = run & bus.a_req & ~bus.a_we;
  assign rd_req[CLI_B] = run & bus.b_req & ~bus.b_we;

  rr_arb2 u_wr_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (wr_req),
    .upd   (1'b1),
    .gnt   (wr_gnt),
    .ptr   (wptr)
  );

  rr_arb2 u_rd_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (rd_req),
    .upd   (~hazard),
    .gnt   (rd_win),
    .ptr   (rptr)
  );

  // Winner index per port steers the address/data muxes.
  assign wr_idx  = (wr_req == 2'b11) ? wptr : wr_req[CLI_B];
  assign rd_idx  = (rd_req == 2'b11) ? rptr : rd_req[CLI_B];
  assign wr_addr = wr_idx ? bus.b_addr  : bus.a_addr;
  assign wr_data = wr_idx ? bus.b_wdata : bus.a_wdata;
  assign rd_addr = rd_idx ? bus.b_addr  : bus.a_addr;

  // A read colliding with this cycle's write waits; its pointer stays put.
  assign hazard = (wr_gnt != 2'b00) && (rd_win != 2'b00) && (rd_addr == wr_addr);
  assign rd_gnt = hazard ? 2'b00 : rd_win;

  assign bus.a_gnt = wr_gnt[CLI_A] | rd_gnt[CLI_A];
  assign bus.b_gnt = wr_gnt[CLI_B] | rd_gnt[CLI_B];

  // State, clear counter and read-return owner/pending register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_INIT;
      clr_cnt_q <= '0;
      rvalid_q  <= 2'b00;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
      rvalid_q  <= rd_gnt;
    end
  end

  // Next state and RAM port drive: clear sweep in INIT, granted traffic in RUN.
  always_comb begin
    state_d     = state_q;
    clr_cnt_d   = '0;
    init_busy   = 1'b0;
    ram_wr_en   = 1'b0;
    ram_wr_addr = wr_addr;
    ram_d_in    = wr_data;
    ram_rd_en   = 1'b0;
    ram_rd_addr = rd_addr;
    unique case (state_q)
      ST_INIT: begin
        init_busy   = 1'b1;
        ram_wr_en   = 1'b1;
        ram_wr_addr = clr_cnt_q;
        ram_d_in    = INIT_VALUE;
        clr_cnt_d   = ADDR_SIZE'(clr_cnt_q + 1'b1);
        if (clr_cnt_q == ADDR_SIZE'(RAM_DEPTH - 1)) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        ram_wr_en = (wr_gnt != 2'b00);
        ram_rd_en = (rd_gnt != 2'b00);
        if (init_req) begin
          state_d = ST_INIT;
        end
      end
      default: state_d = ST_INIT;
    endcase
  end

  // Read data is shared; rvalid marks which client owns it.
  assign bus.a_rvalid = rvalid_q[CLI_A];
  assign bus.b_rvalid = rvalid_q[CLI_B];
  assign bus.a_rdata  = ram_d_out;
  assign bus.b_rdata  = ram_d_out;

endmodule

// File: tb/tb_ram16x8_arbiter.sv
// Directed bench for ram16x8_arbiter with a behavioural 16x8 dual-port RAM.
module tb_ram16x8_arbiter;
  import ram16x8_arbiter_pkg::*;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 init_req;
  logic                 init_busy;
  logic                 ram_wr_en, ram_rd_en;
  logic [ADDR_SIZE-1:0] ram_wr_addr, ram_rd_addr;
  logic [RAM_WIDTH-1:0] ram_d_in, ram_d_out;
  logic [RAM_WIDTH-1:0] mem [RAM_DEPTH];

  int checks = 0;
  int errors = 0;

  ram16x8_arbiter_if bus ();

  ram16x8_arbiter dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .init_req    (init_req),
    .init_busy   (init_busy),
    .ram_wr_en   (ram_wr_en),
    .ram_rd_en   (ram_rd_en),
    .ram_wr_addr (ram_wr_addr),
    .ram_rd_addr (ram_rd_addr),
    .ram_d_in    (ram_d_in),
    .ram_d_out   (ram_d_out)
  );

  always #5 clk = ~clk;

  // Synchronous dual-port RAM: data out one cycle after read enable.
  always @(posedge clk) begin
    if (ram_wr_en) mem[ram_wr_addr] <= ram_d_in;
    if (ram_rd_en) ram_d_out <= mem[ram_rd_addr];
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drv_a(input logic req, input logic we, input logic [3:0] addr, input logic [7:0] wd);
    bus.a_req = req; bus.a_we = we; bus.a_addr = addr; bus.a_wdata = wd;
  endtask

  task automatic drv_b(input logic req, input logic we, input logic [3:0] addr, input logic [7:0] wd);
    bus.b_req = req; bus.b_we = we; bus.b_addr = addr; bus.b_wdata = wd;
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    init_req = 1'b0;
    drv_a(1'b0, 1'b0, 4'h0, 8'h00);
    drv_b(1'b0, 1'b0, 4'h0, 8'h00);

    // Reset state
    #2;
    chk("rst_busy",   8'(init_busy),    8'd1);
    chk("rst_wr_en",  8'(ram_wr_en),    8'd1);
    chk("rst_wr_addr",8'(ram_wr_addr),  8'd0);
    chk("rst_rd_en",  8'(ram_rd_en),    8'd0);
    chk("rst_a_rv",   8'(bus.a_rvalid), 8'd0);
    chk("rst_b_rv",   8'(bus.b_rvalid), 8'd0);
    chk("rst_a_gnt",  8'(bus.a_gnt),    8'd0);
    chk("rst_b_gnt",  8'(bus.b_gnt),    8'd0);

    // Initial clear sweep
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 16; i++) begin
      #1;
      chk("clr_busy", 8'(init_busy),   8'd1);
      chk("clr_addr", 8'(ram_wr_addr), 8'(i));
      chk("clr_data", ram_d_in,        8'h00);
      chk("clr_gnt",  8'(bus.a_gnt),   8'd0);
      tick();
    end
    #1;
    chk("run_busy",  8'(init_busy), 8'd0);
    chk("run_wr_en", 8'(ram_wr_en), 8'd0);
    chk("run_a_gnt", 8'(bus.a_gnt), 8'd0);

    // A writes 10@7 then reads it back
    drv_a(1'b1, 1'b1, 4'h7, 8'h10);
    #1;
    chk("aw_gnt",  8'(bus.a_gnt),   8'd1);
    chk("aw_addr", 8'(ram_wr_addr), 8'h07);
    chk("aw_data", ram_d_in,        8'h10);
    tick();
    drv_a(1'b1, 1'b0, 4'h7, 8'h00);
    #1;
    chk("ar_gnt",   8'(bus.a_gnt),   8'd1);
    chk("ar_rd_en", 8'(ram_rd_en),   8'd1);
    chk("ar_addr",  8'(ram_rd_addr), 8'h07);
    chk("ar_wr_en", 8'(ram_wr_en),   8'd0);
    tick();
    drv_a(1'b0, 1'b0, 4'h0, 8'h00);
    #1;
    chk("ar_rv",   8'(bus.a_rvalid), 8'd1);
    chk("ar_data", bus.a_rdata,      8'h10);
    chk("ar_b_rv", 8'(bus.b_rvalid), 8'd0);

    // Both write every cycle; write pointer favours B after A's last write
    drv_a(1'b1, 1'b1, 4'hA, 8'hAA);
    drv_b(1'b1, 1'b1, 4'hF, 8'hFF);
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("ww_a_gnt", 8'(bus.a_gnt),   (k % 2 == 1) ? 8'd1 : 8'd0);
      chk("ww_b_gnt", 8'(bus.b_gnt),   (k % 2 == 0) ? 8'd1 : 8'd0);
      chk("ww_addr",  8'(ram_wr_addr), (k % 2 == 1) ? 8'h0A : 8'h0F);
      tick();
    end
    drv_a(1'b1, 1'b0, 4'hA, 8'h00);
    drv_b(1'b0, 1'b0, 4'h0, 8'h00);
    #1;
    chk("rA_gnt", 8'(bus.a_gnt), 8'd1);
    tick();
    drv_a(1'b0, 1'b0, 4'h0, 8'h00);
    drv_b(1'b1, 1'b0, 4'hF, 8'h00);
    #1;
    chk("rA_rv",   8'(bus.a_rvalid), 8'd1);
    chk("rA_data", bus.a_rdata,      8'hAA);
    chk("rF_gnt",  8'(bus.b_gnt),    8'd1);
    tick();
    drv_b(1'b0, 1'b0, 4'h0, 8'h00);
    #1;
    chk("rF_rv",   8'(bus.b_rvalid), 8'd1);
    chk("rF_data", bus.b_rdata,      8'hFF);
    chk("rF_a_rv", 8'(bus.a_rvalid), 8'd0);

    // Same-address read during write is held one cycle
    drv_a(1'b1, 1'b1, 4'h3, 8'h55);
    drv_b(1'b1, 1'b0, 4'h3, 8'h00);
    #1;
    chk("hz_a_gnt", 8'(bus.a_gnt), 8'd1);
    chk("hz_b_gnt", 8'(bus.b_gnt), 8'd0);
    chk("hz_rd_en", 8'(ram_rd_en), 8'd0);
    tick();
    drv_a(1'b0, 1'b0, 4'h0, 8'h00);
    #1;
    chk("hz_b_gnt2", 8'(bus.b_gnt), 8'd1);
    chk("hz_rd_en2", 8'(ram_rd_en), 8'd1);
    tick();
    drv_b(1'b0, 1'b0, 4'h0, 8'h00);
    #1;
    chk("hz_b_rv",   8'(bus.b_rvalid), 8'd1);
    chk("hz_b_data", bus.b_rdata,      8'h55);

    // Different addresses: write and read proceed together
    drv_a(1'b1, 1'b1, 4'h2, 8'h22);
    drv_b(1'b1, 1'b0, 4'h9, 8'h00);
    #1;
    chk("wr_rd_a_gnt", 8'(bus.a_gnt), 8'd1);
    chk("wr_rd_b_gnt", 8'(bus.b_gnt), 8'd1);
    chk("wr_rd_wr_en", 8'(ram_wr_en), 8'd1);
    chk("wr_rd_rd_en", 8'(ram_rd_en), 8'd1);
    tick();
    drv_a(1'b0, 1'b0, 4'h0, 8'h00);
    drv_b(1'b0, 1'b0, 4'h0, 8'h00);
    #1;
    chk("r9_rv",   8'(bus.b_rvalid), 8'd1);
    chk("r9_data", bus.b_rdata,      8'h00);

    // Clear on demand; read granted alongside init_req still returns
    drv_a(1'b1, 1'b0, 4'h2, 8'h00);
    init_req = 1'b1;
    #1;
    chk("ir_a_gnt", 8'(bus.a_gnt), 8'd1);
    chk("ir_busy",  8'(init_busy), 8'd0);
    tick();
    init_req = 1'b0;
    drv_a(1'b1, 1'b0, 4'h7, 8'h00);
    #1;
    chk("ir_a_rv",   8'(bus.a_rvalid), 8'd1);
    chk("ir_a_data", bus.a_rdata,      8'h22);
    for (int i = 0; i < 16; i++) begin
      init_req = (i == 5);
      #1;
      chk("clr2_busy",  8'(init_busy),   8'd1);
      chk("clr2_addr",  8'(ram_wr_addr), 8'(i));
      chk("clr2_a_gnt", 8'(bus.a_gnt),   8'd0);
      tick();
    end
    init_req = 1'b0;
    #1;
    chk("r7_gnt",  8'(bus.a_gnt), 8'd1);
    chk("r7_busy", 8'(init_busy), 8'd0);
    tick();
    drv_a(1'b1, 1'b0, 4'hA, 8'h00);
    #1;
    chk("r7_rv",   8'(bus.a_rvalid), 8'd1);
    chk("r7_data", bus.a_rdata,      8'h00);
    tick();
    drv_a(1'b1, 1'b0, 4'hF, 8'h00);
    #1;
    chk("rA2_data", bus.a_rdata, 8'h00);
    tick();
    drv_a(1'b0, 1'b0, 4'h0, 8'h00);
    #1;
    chk("rF2_rv",   8'(bus.a_rvalid), 8'd1);
    chk("rF2_data", bus.a_rdata,      8'h00);

    // Reset drops a pending rvalid immediately
    rst_n = 1'b0;
    #1;
    chk("ar_rv_drop", 8'(bus.a_rvalid), 8'd0);
    chk("ar_busy",    8'(init_busy),    8'd1);
    chk("ar_addr0",   8'(ram_wr_addr),  8'd0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("pre_addr", 8'(ram_wr_addr), 8'(i));
      tick();
    end
    #1;
    chk("mid_addr5", 8'(ram_wr_addr), 8'd5);

    // Reset mid-clear restarts the sweep from address 0
    rst_n = 1'b0;
    #1;
    chk("mid_rst_addr", 8'(ram_wr_addr), 8'd0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 16; i++) begin
      #1;
      chk("clr3_addr", 8'(ram_wr_addr), 8'(i));
      chk("clr3_busy", 8'(init_busy),   8'd1);
      tick();
    end
    #1;
    chk("end_busy", 8'(init_busy), 8'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
